vdp18_cpu_vram_port: RTL and testbench
======================================

Name: vdp18_cpu_vram_port

Overview:
- Parametrised CPU-side VRAM access port for the vdp18 family. It decodes the two-byte control-port sequence and produces register writes and the VRAM address pointer.
- CPU data-port writes and read-ahead requests go into a command FIFO. The FIFO drains only in CPU access slots granted by vdp18_ctrl.
- This decouples CPU bus timing from display fetch timing, and extends addressing beyond 16 KB for successor VDPs.

Parameters:
- ADDR_W, 14: VRAM address width; legal range 14..17. When above 14, the bits above 14 come from register 14.
- FIFO_DEPTH, 4: number of command FIFO entries; power of two, minimum 2.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- rd_i  in  1  CPU read strobe (level).
- wr_i  in  1  CPU write strobe (level).
- mode_i  in  1  port select: 0 = data, 1 = control/status.
- cd_i  in  8  CPU write data.
- cd_o  out  8  CPU read data.
- wait_o  out  1  FIFO full; CPU must hold off data writes.
- status_i  in  8  status byte supplied by the sprite/ctrl logic.
- status_rd_o  out  1  one-cycle pulse on a status read; used to clear flags.
- reg_wr_o  out  1  one-cycle register write strobe.
- reg_num_o  out  6  register number.
- reg_data_o  out  8  register data.
- acc_slot_i  in  1  this cycle is a CPU VRAM slot.
- vram_we_o  out  1  VRAM write enable; valid only when acc_slot_i=1.
- vram_a_o  out  ADDR_W  VRAM address.
- vram_d_o  out  8  VRAM write data.
- vram_d_i  in  8  VRAM read data; valid the cycle after the slot.
- ovf_o  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Strobe detection: register rd_i and wr_i. A CPU access is the single cycle where the strobe is 1 and its registered copy is 0. Only rising edges act.
- Reset values:
  - cd_o=0, all strobes 0, ovf_o=0, wait_o=0, vram_we_o=0, vram_a_o=0, vram_d_o=0.
  - Address pointer 0, latch 0, first-byte flag clear.
  - FIFO flushed (pointers 0, count 0), read-pending flag clear.
  - A reset during a slot cancels that slot's effect and discards any pending read return.
- Control write (mode_i=1):
  - First byte: store in latch, set the first-byte flag.
  - Second byte with bit7=1: pulse reg_wr_o for one cycle with reg_num_o=byte[5:0] and reg_data_o=latch.
    - If ADDR_W>14 and reg_num_o=14, also load pointer[ADDR_W-1:14] from latch[ADDR_W-15:0].
  - Second byte with bit7=0: pointer[13:0] = {byte[5:0], latch}. If bit6=0, queue a read command for the new pointer.
  - The first-byte flag clears after the second byte.
- Status read (mode_i=1 read): cd_o=status_i on the next cycle, pulse status_rd_o, clear the first-byte flag, clear ovf_o.
- Data write (mode_i=0):
  - Clear the first-byte flag.
  - If the FIFO is not full: push {W, pointer, cd_i}, set the read-ahead buffer to cd_i, pointer+1.
  - If the FIFO is full: drop the write, set ovf_o, leave the pointer unchanged.
- Data read (mode_i=0):
  - Clear the first-byte flag and present the read-ahead buffer on cd_o.
  - Push {R, pointer}, pointer+1. If the FIFO is full, the push is dropped and ovf_o is set.
  - A read issued while a previous read is still outstanding returns the stale buffer value; no stall.
- Pointer arithmetic: increments modulo 2^ADDR_W; the all-ones address wraps to 0.
- FIFO entries are in order, holding {is_read, ADDR_W address, 8 data}.
- The head entry is driven combinationally onto vram_a_o / vram_d_o, and vram_we_o = acc_slot_i & !empty & !is_read.
- Slot handling when acc_slot_i=1 and the FIFO is not empty:
  - Pop the head.
  - If it is a read, set the pending flag. On the next cycle, read-ahead buffer = vram_d_i and the pending flag clears.
- A slot with the FIFO empty does nothing.
- A push and a pop in the same cycle leave the count unchanged. This includes the full case: a pop in the same cycle frees a slot, so the push is accepted.
- wait_o = (count == FIFO_DEPTH), registered from the next-state count.

Optional Feature:
- VDP_PORT_HWM_EN defined:
  - Adds fifo_level_o (clog2(FIFO_DEPTH)+1 bits), the current count.
  - Adds fifo_hwm_o (same width), the maximum count since reset or since the last status read; the status read reloads it with the current count.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Control bytes 0x34 then 0x52 → pointer=0x1234, no read queued. Data write 0xAA with a slot → VRAM[0x1234]=0xAA, pointer=0x1235.
- Control bytes 0x07 then 0x81 → reg_wr_o pulses once with reg_num_o=1 and reg_data_o=0x07; pointer unchanged.
- Control bytes 0x00 then 0x10, with VRAM[0x1000]=0x5C, one slot, then a data read → cd_o=0x5C and a new read queued for 0x1001.
- FIFO_DEPTH=4, no slots, 5 data writes → wait_o=1 after the 4th write; the 5th is dropped and ovf_o=1. A status read clears ovf_o. Four slots then write 4 entries in order.
- ADDR_W=17: write reg 14=0x01, set pointer to 0x3FFF, write twice → data at 0x07FFF then 0x08000.
- Push and slot in the same cycle at count=4 → write accepted, count stays 4. Reset asserted mid-slot → FIFO empty, vram_we_o=0, cd_o=0.

Source files
------------

// File: rtl/vdp18_cpu_vram_port.sv
// CPU-side VRAM access port for vdp18: control-port decode, address pointer and a slot-drained command FIFO.
// Optional `VDP_PORT_HWM_EN adds FIFO level and high-water-mark outputs.
module vdp18_cpu_vram_port #(
  parameter int ADDR_W     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic              mode_i,
  input  logic [7:0]        cd_i,
  output logic [7:0]        cd_o,
  output logic              wait_o,
  input  logic [7:0]        status_i,
  output logic              status_rd_o,
  output logic              reg_wr_o,
  output logic [5:0]        reg_num_o,
  output logic [7:0]        reg_data_o,
  input  logic              acc_slot_i,
  output logic              vram_we_o,
  output logic [ADDR_W-1:0] vram_a_o,
  output logic [7:0]        vram_d_o,
  input  logic [7:0]        vram_d_i,
`ifdef VDP_PORT_HWM_EN
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_hwm_o,
`endif
  output logic              ovf_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'(14'h3FFF);

  typedef struct packed {
    logic              is_read;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } cmd_t;

  cmd_t              mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rd_q, wr_q, first_q, first_d, pend_q, pend_d;
  logic [7:0]        latch_q, latch_d, ra_q, ra_d, cd_d, reg_num_pad;
  logic [ADDR_W-1:0] ptr_q, ptr_d, set_ptr, hi_load;
  logic              ovf_d, status_rd_d, reg_wr_d;
  logic [5:0]        reg_num_d;
  logic [7:0]        reg_data_d;
  logic              rd_acc, wr_acc, empty, pop, full_blk, push;
  cmd_t              head, push_cmd;

  assign rd_acc   = rd_i & ~rd_q;
  assign wr_acc   = wr_i & ~wr_q;
  assign empty    = (cnt_q == '0);
  assign pop      = acc_slot_i & ~empty;
  // A pop in the same cycle frees an entry, so a full FIFO still accepts the push.
  assign full_blk = (cnt_q == CW'(FIFO_DEPTH)) & ~pop;
  assign head     = mem[rd_ptr_q];

  assign set_ptr     = (ptr_q & ~LO_MASK) | ADDR_W'({cd_i[5:0], latch_q});
  assign hi_load     = ADDR_W'({latch_q, 14'h0000});
  assign reg_num_pad = {2'b00, cd_i[5:0]};

  // NOTE: every signal gets a default before the decode so no path leaves one unassigned (no latches).
  always_comb begin
    push        = 1'b0;
    push_cmd    = '0;
    ptr_d       = ptr_q;
    first_d     = first_q;
    latch_d     = latch_q;
    ovf_d       = ovf_q_sig();
    cd_d        = cd_o;
    status_rd_d = 1'b0;
    reg_wr_d    = 1'b0;
    reg_num_d   = reg_num_o;
    reg_data_d  = reg_data_o;
    ra_d        = pend_q ? vram_d_i : ra_q;
    pend_d      = pop & head.is_read;

    if (wr_acc) begin
      if (mode_i) begin
        if (!first_q) begin
          latch_d = cd_i;
          first_d = 1'b1;
        end else begin
          first_d = 1'b0;
          if (cd_i[7]) begin
            reg_wr_d   = 1'b1;
            reg_num_d  = cd_i[5:0];
            reg_data_d = latch_q;
            if (ADDR_W > 14 && reg_num_pad == 8'd14)
              ptr_d = (ptr_q & LO_MASK) | hi_load;
          end else begin
            ptr_d = set_ptr;
            if (!cd_i[6]) begin
              if (full_blk) ovf_d = 1'b1;
              else begin
                push     = 1'b1;
                push_cmd = '{is_read: 1'b1, addr: set_ptr, data: 8'h00};
                ptr_d    = set_ptr + ADDR_W'(1);
              end
            end
          end
        end
      end else begin
        first_d = 1'b0;
        if (full_blk) ovf_d = 1'b1;
        else begin
          push     = 1'b1;
          push_cmd = '{is_read: 1'b0, addr: ptr_q, data: cd_i};
          ra_d     = cd_i;  // newer CPU data wins over an older pending read return
          ptr_d    = ptr_q + ADDR_W'(1);
        end
      end
    end else if (rd_acc) begin
      first_d = 1'b0;
      if (mode_i) begin
        cd_d        = status_i;
        status_rd_d = 1'b1;
        ovf_d       = 1'b0;
      end else begin
        cd_d = ra_q;
        if (full_blk) ovf_d = 1'b1;
        else begin
          push     = 1'b1;
          push_cmd = '{is_read: 1'b1, addr: ptr_q, data: 8'h00};
          ptr_d    = ptr_q + ADDR_W'(1);
        end
      end
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  function automatic logic ovf_q_sig();
    return ovf_o;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q <= 1'b0; wr_q <= 1'b0; first_q <= 1'b0; latch_q <= '0;
      ptr_q <= '0; ra_q <= '0; pend_q <= 1'b0;
      wr_ptr_q <= '0; rd_ptr_q <= '0; cnt_q <= '0;
      ovf_o <= 1'b0; wait_o <= 1'b0; cd_o <= '0;
      status_rd_o <= 1'b0; reg_wr_o <= 1'b0; reg_num_o <= '0; reg_data_o <= '0;
    end else begin
      rd_q <= rd_i; wr_q <= wr_i; first_q <= first_d; latch_q <= latch_d;
      ptr_q <= ptr_d; ra_q <= ra_d; pend_q <= pend_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      ovf_o <= ovf_d; wait_o <= (cnt_d == CW'(FIFO_DEPTH)); cd_o <= cd_d;
      status_rd_o <= status_rd_d; reg_wr_o <= reg_wr_d;
      reg_num_o <= reg_num_d; reg_data_o <= reg_data_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (!reset_i && push) mem[wr_ptr_q] <= push_cmd;
  end

  assign vram_we_o = acc_slot_i & ~empty & ~head.is_read & ~reset_i;
  assign vram_a_o  = empty ? '0 : head.addr;
  assign vram_d_o  = empty ? '0 : head.data;

`ifdef VDP_PORT_HWM_EN
  logic [CW-1:0] hwm_q;
  always_ff @(posedge clk_i) begin
    if (reset_i)               hwm_q <= '0;
    else if (status_rd_d)      hwm_q <= cnt_d;
    else if (cnt_d > hwm_q)    hwm_q <= cnt_d;
  end
  assign fifo_level_o = cnt_q;
  assign fifo_hwm_o   = hwm_q;
`endif

endmodule

// File: tb/tb_vdp18_cpu_vram_port.sv
// Scoreboard bench for vdp18_cpu_vram_port: a 14-bit instance and a 17-bit instance, directed vectors.
module tb_vdp18_cpu_vram_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic [7:0] cd = '0, status = '0;
  logic       rd_a = 0, wr_a = 0, slot_a = 0;
  logic       rd_b = 0, wr_b = 0, slot_b = 0;
  logic [7:0] vdi_a = '0, vdi_b = '0;

  logic [7:0]  a_cd, a_rnum8, b_cd, a_vd, b_vd, a_rdata, b_rdata;
  logic [5:0]  a_rnum, b_rnum;
  logic        a_wait, a_srd, a_rwr, a_we, a_ovf;
  logic        b_wait, b_srd, b_rwr, b_we, b_ovf;
  logic [13:0] a_va;
  logic [16:0] b_va;

  int n_checks = 0, n_pass = 0;
  logic [24:0] exp_vw_a[$], exp_vw_b[$];
  logic [13:0] exp_reg_a[$], exp_reg_b[$];
  logic [7:0]  vmem [16384];

  always #5 clk = ~clk;

  vdp18_cpu_vram_port #(.ADDR_W(14), .FIFO_DEPTH(4)) dut_a (
    .clk_i(clk), .reset_i(reset), .rd_i(rd_a), .wr_i(wr_a), .mode_i(mode),
    .cd_i(cd), .cd_o(a_cd), .wait_o(a_wait), .status_i(status), .status_rd_o(a_srd),
    .reg_wr_o(a_rwr), .reg_num_o(a_rnum), .reg_data_o(a_rdata), .acc_slot_i(slot_a),
    .vram_we_o(a_we), .vram_a_o(a_va), .vram_d_o(a_vd), .vram_d_i(vdi_a), .ovf_o(a_ovf));

  vdp18_cpu_vram_port #(.ADDR_W(17), .FIFO_DEPTH(4)) dut_b (
    .clk_i(clk), .reset_i(reset), .rd_i(rd_b), .wr_i(wr_b), .mode_i(mode),
    .cd_i(cd), .cd_o(b_cd), .wait_o(b_wait), .status_i(status), .status_rd_o(b_srd),
    .reg_wr_o(b_rwr), .reg_num_o(b_rnum), .reg_data_o(b_rdata), .acc_slot_i(slot_b),
    .vram_we_o(b_we), .vram_a_o(b_va), .vram_d_o(b_vd), .vram_d_i(vdi_b), .ovf_o(b_ovf));

  assign a_rnum8 = {2'b00, a_rnum};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // VRAM model for instance A: write on slot, read data returned the cycle after the slot.
  initial begin
    for (int i = 0; i < 16384; i++) vmem[i] = 8'h00;
    vmem[14'h1000] = 8'h5C;
  end
  always @(posedge clk) if (slot_a) begin
    if (a_we) vmem[a_va] <= a_vd;
    vdi_a <= vmem[a_va];
  end

  // Monitors: pop and compare whenever the DUT presents a VRAM write or register write.
  always @(negedge clk) begin
    if (a_we) begin
      if (exp_vw_a.size() == 0) check("vw_a_unexpected", {7'd0, 3'd0, a_va, a_vd}, 32'hFFFF_FFFF);
      else check("vw_a", {3'd0, a_va, a_vd}, 32'(exp_vw_a.pop_front()));
    end
    if (b_we) begin
      if (exp_vw_b.size() == 0) check("vw_b_unexpected", {7'd0, b_va, b_vd}, 32'hFFFF_FFFF);
      else check("vw_b", {b_va, b_vd}, 32'(exp_vw_b.pop_front()));
    end
    if (a_rwr) begin
      if (exp_reg_a.size() == 0) check("reg_a_unexpected", {18'd0, a_rnum, a_rdata}, 32'hFFFF_FFFF);
      else check("reg_a", {a_rnum, a_rdata}, 32'(exp_reg_a.pop_front()));
    end
    if (b_rwr) begin
      if (exp_reg_b.size() == 0) check("reg_b_unexpected", {18'd0, b_rnum, b_rdata}, 32'hFFFF_FFFF);
      else check("reg_b", {b_rnum, b_rdata}, 32'(exp_reg_b.pop_front()));
    end
  end

  task automatic cpu_wr(input bit sel, input bit m, input logic [7:0] d);
    @(posedge clk); #1;
    mode = m; cd = d;
    if (sel) wr_b = 1'b1; else wr_a = 1'b1;
    @(posedge clk); #1;
    wr_a = 1'b0; wr_b = 1'b0;
  endtask

  task automatic cpu_rd(input bit sel, input bit m);
    @(posedge clk); #1;
    mode = m;
    if (sel) rd_b = 1'b1; else rd_a = 1'b1;
    @(posedge clk); #1;
    rd_a = 1'b0; rd_b = 1'b0;
  endtask

  task automatic ctrl(input bit sel, input logic [7:0] b1, input logic [7:0] b2);
    cpu_wr(sel, 1'b1, b1);
    cpu_wr(sel, 1'b1, b2);
  endtask

  task automatic slot(input bit sel);
    @(posedge clk); #1;
    if (sel) slot_b = 1'b1; else slot_a = 1'b1;
    @(posedge clk); #1;
    slot_a = 1'b0; slot_b = 1'b0;
  endtask

  // Slot on A that must present a read command for the given address.
  task automatic read_slot(input string name, input logic [13:0] addr);
    @(posedge clk); #1;
    slot_a = 1'b1;
    #1;
    check({name, "_addr"}, 32'(a_va), 32'(addr));
    check({name, "_we"}, 32'(a_we), 32'd0);
    @(posedge clk); #1;
    slot_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_cd", 32'(a_cd), 0);
    check("rst_wait", 32'(a_wait), 0);
    check("rst_ovf", 32'(a_ovf), 0);
    check("rst_we", 32'(a_we), 0);
    check("rst_va", 32'(a_va), 0);
    check("rst_regwr", 32'(a_rwr), 0);
    check("rst_srd", 32'(a_srd), 0);
    check("rst_vb", 32'(b_va), 0);
    reset = 1'b0;

    // Pointer load without read-ahead, then two writes at consecutive addresses.
    ctrl(0, 8'h34, 8'h52);
    exp_vw_a.push_back({3'd0, 14'h1234, 8'hAA});
    cpu_wr(0, 0, 8'hAA);
    slot(0);
    exp_vw_a.push_back({3'd0, 14'h1235, 8'hBB});
    cpu_wr(0, 0, 8'hBB);
    slot(0);

    // Register write leaves the pointer alone.
    exp_reg_a.push_back({6'd1, 8'h07});
    ctrl(0, 8'h07, 8'h81);
    exp_vw_a.push_back({3'd0, 14'h1236, 8'hCC});
    cpu_wr(0, 0, 8'hCC);
    slot(0);

    // Read setup prefetches 0x1000; the data read returns it and queues 0x1001.
    ctrl(0, 8'h00, 8'h10);
    read_slot("setup_rd", 14'h1000);
    @(posedge clk); #1;
    cpu_rd(0, 0);
    check("data_rd_cd", 32'(a_cd), 32'h5C);
    read_slot("next_rd", 14'h1001);

    // Fill the FIFO without slots; fifth write is dropped.
    for (int i = 1; i <= 4; i++) begin
      exp_vw_a.push_back({3'd0, 14'h1002 + 14'(i - 1), 8'(i)});
      cpu_wr(0, 0, 8'(i));
      if (i == 3) check("wait_at_3", 32'(a_wait), 0);
    end
    check("wait_at_4", 32'(a_wait), 1);
    check("ovf_at_4", 32'(a_ovf), 0);
    cpu_wr(0, 0, 8'h05);
    check("ovf_drop", 32'(a_ovf), 1);
    check("wait_drop", 32'(a_wait), 1);
    status = 8'hA5;
    cpu_rd(0, 1);
    check("status_cd", 32'(a_cd), 32'hA5);
    check("status_pulse", 32'(a_srd), 1);
    check("ovf_cleared", 32'(a_ovf), 0);
    @(posedge clk); #1;
    check("status_pulse_end", 32'(a_srd), 0);

    // Push and pop in the same cycle while full: push accepted, still full.
    @(posedge clk); #1;
    mode = 1'b0; cd = 8'h06; wr_a = 1'b1; slot_a = 1'b1;
    exp_vw_a.push_back({3'd0, 14'h1006, 8'h06});
    @(posedge clk); #1;
    wr_a = 1'b0; slot_a = 1'b0;
    check("full_pushpop_wait", 32'(a_wait), 1);
    check("full_pushpop_ovf", 32'(a_ovf), 0);
    repeat (4) slot(0);
    check("drained_wait", 32'(a_wait), 0);

    // Reset during a slot cancels the pending write.
    cpu_wr(0, 0, 8'h77);
    @(posedge clk); #1;
    slot_a = 1'b1; reset = 1'b1;
    #1;
    check("rst_slot_we", 32'(a_we), 0);
    @(posedge clk); #1;
    slot_a = 1'b0; reset = 1'b0;
    check("rst2_cd", 32'(a_cd), 0);
    check("rst2_wait", 32'(a_wait), 0);
    check("rst2_ovf", 32'(a_ovf), 0);
    check("rst2_va", 32'(a_va), 0);
    @(posedge clk); #1;
    slot_a = 1'b1;
    #1;
    check("rst2_empty_we", 32'(a_we), 0);
    @(posedge clk); #1;
    slot_a = 1'b0;

    // 14-bit pointer wraps from all-ones to zero.
    ctrl(0, 8'hFF, 8'h7F);
    exp_vw_a.push_back({3'd0, 14'h3FFF, 8'hE1});
    cpu_wr(0, 0, 8'hE1);
    exp_vw_a.push_back({3'd0, 14'h0000, 8'hE2});
    cpu_wr(0, 0, 8'hE2);
    slot(0);
    slot(0);

    // 17-bit instance: register 14 supplies the upper address bits.
    exp_reg_b.push_back({6'd14, 8'h01});
    ctrl(1, 8'h01, 8'h8E);
    ctrl(1, 8'hFF, 8'h7F);
    exp_vw_b.push_back({17'h07FFF, 8'hD1});
    cpu_wr(1, 0, 8'hD1);
    exp_vw_b.push_back({17'h08000, 8'hD2});
    cpu_wr(1, 0, 8'hD2);
    slot(1);
    slot(1);

    repeat (3) @(posedge clk);
    #1;
    check("vw_a_left", 32'(exp_vw_a.size()), 0);
    check("vw_b_left", 32'(exp_vw_b.size()), 0);
    check("reg_a_left", 32'(exp_reg_a.size()), 0);
    check("reg_b_left", 32'(exp_reg_b.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
